// File: rtl/moving_average.sv
// Moving average over the last 2^DEPTH_LOG2 accepted samples, kept in a circular buffer with a running sum.
// Optional macro MOVING_AVERAGE_ROUND_EN selects round-half-up instead of truncation for avg and y.
module moving_average #(
    parameter int DATA_W     = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_load,
    input  logic [DATA_W-1:0] x,
    input  logic              clr,
    output logic [DATA_W-1:0] avg,
    output logic              avg_valid,
    output logic              y
);

    localparam int N     = 1 << DEPTH_LOG2;
    localparam int SUM_W = DATA_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] N_CNT = (DEPTH_LOG2+1)'(N);

    logic [DATA_W-1:0]     buffer [N];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [SUM_W-1:0]      sum;

    logic [DATA_W-1:0]     old_entry;
    logic [SUM_W-1:0]      sum_next;
    logic [DEPTH_LOG2:0]   count_next;
    logic [DATA_W-1:0]     avg_next;
    logic                  y_next;

`ifdef MOVING_AVERAGE_ROUND_EN
    logic [SUM_W:0]        sum_rnd;
`endif

    always_comb begin
        old_entry  = buffer[wr_ptr];
        // sum always covers old_entry, so the subtraction cannot wrap
        sum_next   = sum + SUM_W'(x) - SUM_W'(old_entry);
        count_next = (count == N_CNT) ? count : count + 1'b1;
`ifdef MOVING_AVERAGE_ROUND_EN
        sum_rnd    = {1'b0, sum_next} + (SUM_W+1)'(N / 2);
        avg_next   = sum_rnd[DEPTH_LOG2 +: DATA_W];
`else
        avg_next   = sum_next[DEPTH_LOG2 +: DATA_W];
`endif
        y_next     = (x > avg_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) buffer[i] <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            sum       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
            y         <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) buffer[i] <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            sum       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
            y         <= 1'b0;
        end else if (x_load) begin
            buffer[wr_ptr] <= x;
            wr_ptr    <= wr_ptr + 1'b1;
            count     <= count_next;
            sum       <= sum_next;
            avg       <= avg_next;
            avg_valid <= (count_next == N_CNT);
            y         <= y_next;
        end
    end

endmodule

// File: tb/tb_moving_average.sv
// Bench for moving_average: directed window scenarios plus random traffic against a queue-based model.
module tb_moving_average;

    logic       clk = 1'b0;
    logic       rst;
    logic       x_load, clr;
    logic [3:0] x;
    logic [3:0] avg;
    logic       avg_valid, y;

    logic       x_load8, clr8;
    logic [7:0] x8;
    logic [7:0] avg8;
    logic       avg_valid8, y8;

    int total = 0;
    int bad   = 0;

    int hist[$];
    int exp_avg, exp_y;

    always #5 clk = ~clk;

    moving_average #(.DATA_W(4), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .x_load(x_load), .x(x), .clr(clr),
        .avg(avg), .avg_valid(avg_valid), .y(y)
    );

    moving_average #(.DATA_W(8), .DEPTH_LOG2(3)) dut8 (
        .clk(clk), .rst(rst), .x_load(x_load8), .x(x8), .clr(clr8),
        .avg(avg8), .avg_valid(avg_valid8), .y(y8)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // average of the last n accepted samples, missing ones counted as zero
    function automatic int window_avg(input int q[$], input int n);
        int s = 0;
        for (int i = 0; i < q.size(); i++) s += q[i];
`ifdef MOVING_AVERAGE_ROUND_EN
        return (s + n / 2) / n;
`else
        return s / n;
`endif
    endfunction

    task automatic model_clear();
        hist.delete();
        exp_avg = 0;
        exp_y   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".avg"},   int'(avg),       exp_avg);
        check({tag, ".y"},     int'(y),         exp_y);
        check({tag, ".valid"}, int'(avg_valid), (hist.size() == 4) ? 1 : 0);
    endtask

    task automatic cycle(input logic ld, input int xv, input logic cl, input string tag);
        x_load = ld;
        x      = 4'(xv);
        clr    = cl;
        @(posedge clk);
        if (cl) begin
            model_clear();
        end else if (ld) begin
            hist.push_back(xv);
            if (hist.size() > 4) void'(hist.pop_front());
            exp_avg = window_avg(hist, 4);
            exp_y   = (xv > exp_avg) ? 1 : 0;
        end
        #1;
        check_outputs(tag);
        x_load = 1'b0;
        clr    = 1'b0;
    endtask

    initial begin
        int fill[4];
        int r;
        fill = '{5, 7, 4, 8};
        rst = 1'b0; x_load = 0; clr = 0; x = 0;
        x_load8 = 0; clr8 = 0; x8 = 0;
        model_clear();
        #12;
        check_outputs("reset");
        check("reset8.avg", int'(avg8), 0);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) cycle(1'b1, fill[i], 1'b0, "fill");
        check("fill.avg_lit",   int'(avg),       6);
        check("fill.y_lit",     int'(y),         1);
        check("fill.valid_lit", int'(avg_valid), 1);

        cycle(1'b1, 15, 1'b0, "slide");
`ifdef MOVING_AVERAGE_ROUND_EN
        check("slide.avg_lit", int'(avg), 9);
`else
        check("slide.avg_lit", int'(avg), 8);
`endif
        check("slide.y_lit", int'(y), 1);

        for (int i = 0; i < 3; i++) cycle(1'b0, 9, 1'b0, "hold");
        for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0, "zeros");
        check("zeros.avg_lit", int'(avg), 0);
        check("zeros.y_lit",   int'(y),   0);

        cycle(1'b1, 15, 1'b1, "clr_collide");
        check("clr_collide.valid_lit", int'(avg_valid), 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3, 1'b0, "refill3");
        check("refill3.avg_lit", int'(avg), 3);
        check("refill3.y_lit",   int'(y),   0);

        // async reset landing between edges, mid-window
        cycle(1'b1, 12, 1'b0, "pre_rst");
        cycle(1'b1, 14, 1'b0, "pre_rst");
        #3 rst = 1'b0;
        #1;
        model_clear();
        check_outputs("async_rst");
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 10 + i, 1'b0, "post_rst");

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            cycle(r < 60, $urandom_range(0, 15), r >= 95, "random");
        end

        // wide configuration: all-ones window must not overflow
        for (int i = 0; i < 8; i++) begin
            x_load8 = 1'b1;
            x8      = 8'd255;
            @(posedge clk);
            #1;
            check("wide.valid", int'(avg_valid8), (i == 7) ? 1 : 0);
        end
        x_load8 = 1'b0;
        check("wide.avg", int'(avg8), 255);
        check("wide.y",   int'(y8),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
